// File: rtl/if_id_ibuf.sv
// IF/ID decoupling buffer: a circular queue of fetched instructions that fetch fills 0-2 per cycle and decode drains 0-2 per cycle.
// Optional same-cycle bypass of an empty buffer is enabled by defining IBUF_BYPASS_EN.
module if_id_ibuf #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 push_num,
  input  logic [AW-1:0]              pc_i,
  input  logic [DW-1:0]              inst1_i,
  input  logic [DW-1:0]              inst2_i,
  input  logic [AW-1:0]              npc_i,
  input  logic                       branch_flag_i,
  output logic                       in_ready,
  input  logic [1:0]                 pop_num,
  output logic                       valid1_o,
  output logic [AW-1:0]              pc1_o,
  output logic [DW-1:0]              inst1_o,
  output logic [AW-1:0]              npc1_o,
  output logic                       bflag1_o,
  output logic                       valid2_o,
  output logic [AW-1:0]              pc2_o,
  output logic [DW-1:0]              inst2_o,
  output logic [AW-1:0]              npc2_o,
  output logic                       bflag2_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_inst [DEPTH];
  logic [AW-1:0] mem_npc  [DEPTH];
  logic          mem_bf   [DEPTH];

  // Handshake: fetch's push_num is taken only while in_ready is high (from the
  // registered count, so a same-cycle pop gives no credit); fetch holds its data
  // otherwise. pop_num is a demand from decode, clipped to what is available.
  logic          push_ok, byp;
  logic [1:0]    push_acc, pop_c, eff_pop;
  logic [CW-1:0] avail;
  logic [AW-1:0] e0_npc, e1_pc;
  logic          e0_bf;
  logic [PW-1:0] wr1, rd1;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count_o  = count_q;

  always_comb begin
    push_ok  = in_ready && !flush && (push_num == 2'd1 || push_num == 2'd2);
    push_acc = push_ok ? push_num : 2'd0;
    e1_pc    = pc_i + AW'(4);
    e0_npc   = (push_num == 2'd2) ? e1_pc : npc_i;
    e0_bf    = (push_num == 2'd2) ? 1'b0 : branch_flag_i;
    wr1      = wr_ptr_q + PW'(1);
    rd1      = rd_ptr_q + PW'(1);
`ifdef IBUF_BYPASS_EN
    byp      = (count_q == '0) && push_ok;
`else
    byp      = 1'b0;
`endif
    // Bypassed instructions count as available, so a same-cycle pop consumes them.
    avail    = count_q + (byp ? CW'(push_acc) : CW'(0));
    pop_c    = (pop_num == 2'd3) ? 2'd2 : pop_num;
    eff_pop  = (avail >= CW'(pop_c)) ? pop_c : avail[1:0];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(eff_pop);
      wr_ptr_d = wr_ptr_q + PW'(push_acc);
      count_d  = count_q + CW'(push_acc) - CW'(eff_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; lane valids hide stale contents.
  // A bypassed-and-popped entry is still written, but rd_ptr skips past it.
  always_ff @(posedge clk) begin
    if (push_acc != 2'd0) begin
      mem_pc[wr_ptr_q]   <= pc_i;
      mem_inst[wr_ptr_q] <= inst1_i;
      mem_npc[wr_ptr_q]  <= e0_npc;
      mem_bf[wr_ptr_q]   <= e0_bf;
    end
    if (push_acc == 2'd2) begin
      mem_pc[wr1]   <= e1_pc;
      mem_inst[wr1] <= inst2_i;
      mem_npc[wr1]  <= npc_i;
      mem_bf[wr1]   <= branch_flag_i;
    end
  end

  always_comb begin
    valid1_o = 1'b0;
    pc1_o    = '0;
    inst1_o  = '0;
    npc1_o   = '0;
    bflag1_o = 1'b0;
    valid2_o = 1'b0;
    pc2_o    = '0;
    inst2_o  = '0;
    npc2_o   = '0;
    bflag2_o = 1'b0;
    if (byp) begin
      valid1_o = 1'b1;
      pc1_o    = pc_i;
      inst1_o  = inst1_i;
      npc1_o   = e0_npc;
      bflag1_o = e0_bf;
      if (push_acc == 2'd2) begin
        valid2_o = 1'b1;
        pc2_o    = e1_pc;
        inst2_o  = inst2_i;
        npc2_o   = npc_i;
        bflag2_o = branch_flag_i;
      end
    end else begin
      if (count_q >= CW'(1)) begin
        valid1_o = 1'b1;
        pc1_o    = mem_pc[rd_ptr_q];
        inst1_o  = mem_inst[rd_ptr_q];
        npc1_o   = mem_npc[rd_ptr_q];
        bflag1_o = mem_bf[rd_ptr_q];
      end
      if (count_q >= CW'(2)) begin
        valid2_o = 1'b1;
        pc2_o    = mem_pc[rd1];
        inst2_o  = mem_inst[rd1];
        npc2_o   = mem_npc[rd1];
        bflag2_o = mem_bf[rd1];
      end
    end
  end

endmodule

// File: tb/tb_if_id_ibuf.sv
// Directed bench for if_id_ibuf (DEPTH=8): hand-checked vectors plus a queue reference of buffer contents.
module tb_if_id_ibuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  push_num = 2'd0;
  logic [31:0] pc_i = '0, inst1_i = '0, inst2_i = '0, npc_i = '0;
  logic        branch_flag_i = 1'b0;
  logic        in_ready;
  logic [1:0]  pop_num = 2'd0;
  logic        valid1_o, bflag1_o, valid2_o, bflag2_o;
  logic [31:0] pc1_o, inst1_o, npc1_o, pc2_o, inst2_o, npc2_o;
  logic [3:0]  count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        bf;
  } ent_t;

  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  if_id_ibuf #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_num(push_num), .pc_i(pc_i),
    .inst1_i(inst1_i), .inst2_i(inst2_i), .npc_i(npc_i), .branch_flag_i(branch_flag_i),
    .in_ready(in_ready), .pop_num(pop_num),
    .valid1_o(valid1_o), .pc1_o(pc1_o), .inst1_o(inst1_o), .npc1_o(npc1_o), .bflag1_o(bflag1_o),
    .valid2_o(valid2_o), .pc2_o(pc2_o), .inst2_o(inst2_o), .npc2_o(npc2_o), .bflag2_o(bflag2_o),
    .count_o(count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_model(input int pop_n);
    int k;
    k = (pop_n > 2) ? 2 : pop_n;
    while (k > 0 && mq.size() > 0) begin
      void'(mq.pop_front());
      k--;
    end
  endtask

  task automatic chk_lanes();
    ent_t e1, e2;
    int   n;
    n  = mq.size();
    e1 = (n >= 1) ? mq[0] : '0;
    e2 = (n >= 2) ? mq[1] : '0;
    check("count", 64'(count_o), 64'(n));
    check("valid1", 64'(valid1_o), 64'(n >= 1));
    check("valid2", 64'(valid2_o), 64'(n >= 2));
    check("in_ready", 64'(in_ready), 64'(n <= 6));
    check("pc1", 64'(pc1_o), 64'(e1.pc));
    check("inst1", 64'(inst1_o), 64'(e1.inst));
    check("npc1", 64'(npc1_o), 64'(e1.npc));
    check("bflag1", 64'(bflag1_o), 64'(e1.bf));
    check("pc2", 64'(pc2_o), 64'(e2.pc));
    check("inst2", 64'(inst2_o), 64'(e2.inst));
    check("npc2", 64'(npc2_o), 64'(e2.npc));
    check("bflag2", 64'(bflag2_o), 64'(e2.bf));
  endtask

  // driver: one clock cycle of stimulus, reference update, then lane check
  task automatic step(input int pn, input logic [31:0] pc, input logic [31:0] i1,
                      input logic [31:0] i2, input logic [31:0] npc, input logic bf,
                      input int pop_n, input logic fl);
    ent_t a, b;
    int   n_push;
    bit   byp;
    push_num = 2'(pn); pc_i = pc; inst1_i = i1; inst2_i = i2; npc_i = npc;
    branch_flag_i = bf; pop_num = 2'(pop_n); flush = fl;
    if (fl) begin
      mq.delete();
    end else begin
      n_push = (mq.size() <= 6 && (pn == 1 || pn == 2)) ? pn : 0;
      a.pc = pc; a.inst = i1;
      a.npc = (pn == 2) ? pc + 32'd4 : npc;
      a.bf  = (pn == 2) ? 1'b0 : bf;
      b.pc = pc + 32'd4; b.inst = i2; b.npc = npc; b.bf = bf;
      byp = 1'b0;
`ifdef IBUF_BYPASS_EN
      byp = (mq.size() == 0 && n_push > 0);
`endif
      if (!byp) pop_model(pop_n);
      if (n_push >= 1) mq.push_back(a);
      if (n_push == 2) mq.push_back(b);
      if (byp) pop_model(pop_n);
    end
    @(posedge clk);
    #1;
    push_num = 2'd0; pop_num = 2'd0; flush = 1'b0;
    chk_lanes();
  endtask

  initial begin
    logic [31:0] p;
    // reset state
    #2;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid1", 64'(valid1_o), 64'd0);
    check("rst_valid2", 64'(valid2_o), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pc1", 64'(pc1_o), 64'd0);
    #1 rst = 1'b1;

    // two-wide push: first entry gets pc+4 / not-taken, second gets the prediction
    step(2, 32'h100, 32'hA, 32'hB, 32'h200, 1'b1, 0, 1'b0);
    check("t2_pc1", 64'(pc1_o), 64'h100);
    check("t2_npc1", 64'(npc1_o), 64'h104);
    check("t2_bflag1", 64'(bflag1_o), 64'd0);
    check("t2_pc2", 64'(pc2_o), 64'h104);
    check("t2_npc2", 64'(npc2_o), 64'h200);
    check("t2_bflag2", 64'(bflag2_o), 64'd1);
    check("t2_count", 64'(count_o), 64'd2);

    step(0, 0, 0, 0, 0, 1'b0, 1, 1'b0);
    check("pop1_pc1", 64'(pc1_o), 64'h104);
    check("pop1_pc2_gated", 64'(pc2_o), 64'd0);
    // pop 2 with only one entry removes just that one
    step(0, 0, 0, 0, 0, 1'b0, 2, 1'b0);
    check("pop2_at1_count", 64'(count_o), 64'd0);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      p = 32'h1000 + 32'(8 * i);
      step(2, p, p, p + 32'd4, p + 32'd8, 1'b0, 0, 1'b0);
      if (i == 2) check("fill_ready_at6", 64'(in_ready), 64'd1);
    end
    check("full_count", 64'(count_o), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    // push+pop at full: push refused (in_ready low), pop still happens
    step(2, 32'h2000, 32'h2000, 32'h2004, 32'h2008, 1'b0, 2, 1'b0);
    check("full_pushpop_count", 64'(count_o), 64'd6);
    check("full_pushpop_pc1", 64'(pc1_o), 64'h1008);
    step(2, 32'h1020, 32'h1020, 32'h1024, 32'h1028, 1'b0, 0, 1'b0);
    check("refill_count", 64'(count_o), 64'd8);
    step(0, 0, 0, 0, 0, 1'b0, 1, 1'b0);
    check("c7_ready", 64'(in_ready), 64'd0);
    step(2, 32'h3000, 32'h3000, 32'h3004, 32'h3008, 1'b0, 0, 1'b0);
    check("c7_push_dropped", 64'(count_o), 64'd7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1'b0, 2, 1'b0);

    // steady push 2 / pop 2 across pointer wrap
    step(2, 32'h4000, 32'h4000, 32'h4004, 32'h4008, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      p = 32'h4008 + 32'(8 * i);
      step(2, p, ~p, p ^ 32'h5, p + 32'd8, 1'(i), 2, 1'b0);
      check("wrap_pc1", 64'(pc1_o), 64'(p));
    end
    step(0, 0, 0, 0, 0, 1'b0, 2, 1'b0);

    // flush wins over push and pop
    step(2, 32'h5000, 32'h51, 32'h52, 32'h5008, 1'b0, 0, 1'b0);
    step(2, 32'h5008, 32'h53, 32'h54, 32'h5010, 1'b1, 0, 1'b0);
    step(1, 32'h5010, 32'h55, 32'h0, 32'h5014, 1'b0, 0, 1'b0);
    check("pre_flush_count", 64'(count_o), 64'd5);
    step(2, 32'h6000, 32'h61, 32'h62, 32'h6008, 1'b1, 1, 1'b1);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid1", 64'(valid1_o), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    step(1, 32'h7000, 32'h71, 32'h0, 32'h7004, 1'b0, 0, 1'b0);
    check("post_flush_pc1", 64'(pc1_o), 64'h7000);

    // asynchronous reset mid-traffic, observed before the next edge
    step(2, 32'h8000, 32'h81, 32'h82, 32'h8008, 1'b0, 0, 1'b0);
    push_num = 2'd2; pc_i = 32'h9000; pop_num = 2'd1;
    #3 rst = 1'b0;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_valid1", 64'(valid1_o), 64'd0);
    check("arst_valid2", 64'(valid2_o), 64'd0);
    check("arst_pc1", 64'(pc1_o), 64'd0);
    check("arst_inst1", 64'(inst1_o), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    mq.delete();
    push_num = 2'd0; pop_num = 2'd0;
    #2 rst = 1'b1;
    step(0, 0, 0, 0, 0, 1'b0, 0, 1'b0);

`ifdef IBUF_BYPASS_EN
    push_num = 2'd1; pc_i = 32'hA000; inst1_i = 32'hA1; npc_i = 32'hA004;
    branch_flag_i = 1'b0; pop_num = 2'd1;
    #1;
    check("byp_valid1", 64'(valid1_o), 64'd1);
    check("byp_inst1", 64'(inst1_o), 64'hA1);
    check("byp_pc1", 64'(pc1_o), 64'hA000);
    @(posedge clk);
    #1;
    push_num = 2'd0; pop_num = 2'd0;
    check("byp_count", 64'(count_o), 64'd0);
`else
    push_num = 2'd1; pc_i = 32'hA000; inst1_i = 32'hA1; pop_num = 2'd0;
    #1;
    check("nobyp_valid1", 64'(valid1_o), 64'd0);
    @(posedge clk);
    #1;
    push_num = 2'd0;
    check("nobyp_count", 64'(count_o), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
